// File: rtl/org8_serial_if.sv
// Handshake bundle for the bit-serial OR unit: operand request side and result response side.
interface org8_serial_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             any;
  logic             busy;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, out, any, busy
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, out, any, busy
  );
endinterface

// File: rtl/org8_serial.sv
// Bit-serial OR: operands enter in parallel, are ORed LSB first through one 1-bit cell,
// and the result is rebuilt in a shift register before being handed back in parallel.

module org8_or_cell (
  input  logic a,
  input  logic b,
  output logic o
);
  assign o = a | b;
endmodule

module org8_serial #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  org8_serial_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] res;
  logic             bit_or;
  logic [WIDTH-1:0] res_nxt;

  org8_or_cell u_cell (
    .a (xs[0]),
    .b (ys[0]),
    .o (bit_or)
  );

  // Result fills from the top so that after WIDTH shifts bit 0 sits at res[0].
  assign res_nxt = {bit_or, res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      xs            <= '0;
      ys            <= '0;
      res           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
      bus.any       <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            xs           <= bus.x;
            ys           <= bus.y;
            res          <= '0;
            cnt          <= '0;
            bus.out      <= '0;
            bus.any      <= 1'b0;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          res <= res_nxt;
          xs  <= xs >> 1;
          ys  <= ys >> 1;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            bus.out       <= res_nxt;
            bus.any       <= |res_nxt;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          // out/any stay put here until downstream takes them; no direct restart.
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule
